// File: rtl/button_if.sv
// button_if: button pin levels in, conditioned level and event pulses out
interface button_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_act;
    modport master(output btn_in, input btn_level, btn_press, btn_release, btn_act);
    modport slave(input btn_in, output btn_level, btn_press, btn_release, btn_act);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, counter debouncer, press/release pulses
// and hold-to-repeat act pulse train
module button_conditioner #(
    parameter int               N_BTN        = 3,
    parameter int               DB_CYCLES    = 250000,
    parameter int               REPEAT_DELAY = 12500000,
    parameter int               REPEAT_RATE  = 2500000,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = 3'b011,
    parameter int               CNT_W        = 24
) (
    input logic   clk,
    input logic   reset,
    button_if.slave bus
);
    localparam int MAX_A = DB_CYCLES > REPEAT_DELAY ? DB_CYCLES : REPEAT_DELAY;
    localparam int MAX_C = MAX_A > REPEAT_RATE ? MAX_A : REPEAT_RATE;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    if (64'(MAX_C) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured cycle counts");
    end

    logic [N_BTN-1:0] s1_q, s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.btn_in;
            s2_q <= s1_q;
        end
    end

    for (genvar c = 0; c < N_BTN; c++) begin : g_ch
        logic [CNT_W-1:0] db_cnt_q, db_cnt_d, rp_cnt_q, rp_cnt_d;
        logic [1:0]       st_q, st_d;
        logic             lvl_q, lvl_d, press_q, press_d, rel_q, rel_d, act_q, act_d;
        logic             diff, acc;

        // FSM reacts to the next-cycle level so release and return to IDLE share an edge
        always_comb begin
            diff     = s2_q[c] != lvl_q;
            acc      = diff && db_cnt_q == DB_LAST;
            lvl_d    = acc ? s2_q[c] : lvl_q;
            db_cnt_d = (!diff || acc) ? '0 : db_cnt_q + ONE;
            press_d  = acc && s2_q[c];
            rel_d    = acc && !s2_q[c];
            st_d     = st_q;
            rp_cnt_d = rp_cnt_q;
            act_d    = press_d;
            if (!REPEAT_MASK[c]) begin
                st_d     = IDLE;
                rp_cnt_d = '0;
            end else if (st_q == IDLE) begin
                st_d     = press_d ? DELAY : IDLE;
                rp_cnt_d = press_d ? ONE : '0;
            end else if (!lvl_d) begin
                st_d     = IDLE;
                rp_cnt_d = '0;
            end else if (st_q == DELAY) begin
                st_d     = rp_cnt_q == RD_LAST ? REPEAT : DELAY;
                rp_cnt_d = rp_cnt_q == RD_LAST ? '0 : rp_cnt_q + ONE;
            end else begin
                act_d    = rp_cnt_q == '0;
                rp_cnt_d = rp_cnt_q == RR_LAST ? '0 : rp_cnt_q + ONE;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                db_cnt_q <= '0;
                rp_cnt_q <= '0;
                st_q     <= IDLE;
                lvl_q    <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                act_q    <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                rp_cnt_q <= rp_cnt_d;
                st_q     <= st_d;
                lvl_q    <= lvl_d;
                press_q  <= press_d;
                rel_q    <= rel_d;
                act_q    <= act_d;
            end
        end

        assign bus.btn_level[c]   = lvl_q;
        assign bus.btn_press[c]   = press_q;
        assign bus.btn_release[c] = rel_q;
        assign bus.btn_act[c]     = act_q;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed test-plan scenarios then random button activity,
// checked cycle by cycle against a window-based reference model through a scoreboard
module tb_button_conditioner;
    localparam int N = 3, DB = 4, RD = 10, RR = 3;
    localparam logic [N-1:0] MASK = 3'b011;

    logic clk = 1'b0;
    logic reset = 1'b0;
    button_if #(.N_BTN(N)) bus ();

    button_conditioner #(
        .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
        .REPEAT_MASK(MASK), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] act;
    } exp_t;

    int checks = 0, errors = 0;
    exp_t sb[$];

    logic [N-1:0] m1 = '0, m2 = '0, lvl = '0;
    logic [N-1:0] win[$];
    int ec = 0;
    int pe[N];

    always @(negedge reset) begin
        m1 = '0;
        m2 = '0;
        lvl = '0;
        win.delete();
        ec = 0;
    end

    // level flips once the last DB synchronised samples all disagree with it;
    // act pulses are placed arithmetically from the press edge
    always @(posedge clk) begin
        exp_t e;
        logic [N-1:0] pre;
        bit all;
        int t;
        e = '0;
        if (reset) begin
            ec++;
            pre = m2;
            m2 = m1;
            m1 = bus.btn_in;
            win.push_back(pre);
            if (win.size() > DB) void'(win.pop_front());
            for (int c = 0; c < N; c++) begin
                all = win.size() == DB;
                for (int j = 0; j < win.size(); j++) if (win[j][c] == lvl[c]) all = 0;
                if (all) begin
                    lvl[c] = ~lvl[c];
                    if (lvl[c]) begin
                        e.prs[c] = 1'b1;
                        pe[c] = ec;
                    end else e.rel[c] = 1'b1;
                end
                t = ec - pe[c];
                e.act[c] = lvl[c] && (t == 0 || (MASK[c] && t >= RD && (t - RD) % RR == 0));
            end
            e.lvl = lvl;
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e, g;
        g = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_act};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            if (g !== e) begin
                errors++;
                $display("FAIL outputs at %0t got lvl=%b prs=%b rel=%b act=%b want lvl=%b prs=%b rel=%b act=%b",
                         $time, g.lvl, g.prs, g.rel, g.act, e.lvl, e.prs, e.rel, e.act);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic rst_pulse(input int hold);
        #2 reset = 1'b0;
        #1 checks++;
        if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_act} !== '0) begin
            errors++;
            $display("FAIL async_reset at %0t got lvl=%b prs=%b rel=%b act=%b want all 0",
                     $time, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_act);
        end
        step(hold);
        reset = 1'b1;
    endtask

    initial begin
        bus.btn_in = '1;
        step(3);
        reset = 1'b1;
        step(20);
        bus.btn_in = '0;
        step(15);
        bus.btn_in = 3'b100;
        step(3);
        bus.btn_in = '0;
        step(10);
        bus.btn_in = 3'b100;
        step(40);
        bus.btn_in = '0;
        step(15);
        bus.btn_in = 3'b001;
        step(30);
        bus.btn_in = '0;
        step(15);
        bus.btn_in = 3'b010;
        step(7);
        bus.btn_in = '0;
        step(15);
        bus.btn_in = 3'b011;
        step(22);
        rst_pulse(5);
        step(15);
        bus.btn_in = '0;
        step(15);
        for (int k = 0; k < 60; k++) begin
            bus.btn_in = N'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) rst_pulse($urandom_range(1, 4));
            step($urandom_range(1, 25));
        end
        bus.btn_in = '0;
        step(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised front-end conditioner for the game's push-button inputs (left, right, fire, and any future buttons). It sits between the board pins and the game core.
- Per channel it provides:
  - a 2-flop synchroniser;
  - a counter debouncer;
  - one-cycle press and release pulses;
  - an optional hold-to-repeat "act" pulse train, so the crosshair keeps moving while a direction button is held.
- All N_BTN channels are independent copies sharing one clock and reset.

Parameters:
- N_BTN, 3, number of button channels (bit 0 = izq, 1 = der, 2 = fire in the top level).
- DB_CYCLES, 250000, consecutive stable synchronised samples required to accept a level change (>=2).
- REPEAT_DELAY, 12500000, cycles from press pulse to the first repeat act pulse (>=2).
- REPEAT_RATE, 2500000, cycles between subsequent repeat act pulses (>=2).
- REPEAT_MASK, 3'b011, per-channel auto-repeat enable (1 = repeat; fire does not repeat by default).
- CNT_W, 24, counter width; must hold max(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_in  in  N_BTN  raw asynchronous button levels, active-high.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle pulse on accepted 0->1.
- btn_release  out  N_BTN  one-cycle pulse on accepted 1->0.
- btn_act  out  N_BTN  one-cycle pulse on the press, plus repeat pulses while held (masked channels).

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs are 0;
  - sync flops, stable levels and all counters are 0;
  - every repeat FSM is in IDLE.
  - Reset asserted mid-debounce or mid-repeat abandons the operation; after release a held button is re-debounced from 0.
- Synchroniser: s1<=btn_in, s2<=s1 on each rising clk. Only s2 is used downstream.
- Debounce (per channel), with db_cnt and stable (stable = btn_level):
  - if s2==stable: db_cnt<=0;
  - else if db_cnt==DB_CYCLES-1: stable<=s2, db_cnt<=0;
  - else db_cnt<=db_cnt+1.
  - Any glitch shorter than DB_CYCLES samples leaves stable unchanged and restarts the count.
  - Latency: btn_in change held steadily -> btn_level changes on the (2+DB_CYCLES)th rising edge.
- btn_press / btn_release:
  - registered, high for exactly the first cycle in which btn_level shows its new value;
  - never both high on one channel in the same cycle.
- Repeat FSM (per channel), states IDLE, DELAY, REPEAT, counter rp_cnt:
  - IDLE: on accepted press -> DELAY, rp_cnt<=1; btn_act pulses together with btn_press.
  - DELAY: if level==0 -> IDLE. Else if rp_cnt==REPEAT_DELAY-1 -> REPEAT, rp_cnt<=0, btn_act pulse next cycle. Else rp_cnt++.
  - First repeat act pulse is therefore exactly REPEAT_DELAY cycles after the press pulse.
  - REPEAT: act pulse every REPEAT_RATE cycles while level==1; level==0 -> IDLE immediately, with no further act pulses.
  - Channels with REPEAT_MASK bit 0 stay in IDLE; btn_act equals btn_press for them.
- Release pulse and return to IDLE occur on the same edge.
- A new press after release restarts from DELAY; no residual count is carried over.
- Simultaneous events: several channels may pulse in the same cycle. There is no priority or arbitration.
- Counters never wrap: each saturates via its compare-and-clear. CNT_W is checked at elaboration.

Test Plan:
All scenarios use N_BTN=3, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=3'b011.
1. Reset: reset=0 with btn_in=3'b111 -> all outputs 0. Release reset with btn_in held -> btn_level=3'b111 at edge 6 after release; btn_press=3'b111 for exactly 1 cycle.
2. Glitch reject: btn_in[2] high for 3 cycles, then low -> btn_level[2], btn_press[2] and btn_act[2] stay 0 throughout.
3. Fire, no repeat: btn_in[2] high for 40 cycles -> exactly one btn_act[2] pulse (with press). btn_release[2] occurs 6 edges after the input falls.
4. Auto-repeat: btn_in[0] held for 30 cycles -> btn_act[0] pulses at press (t=P), then at P+10, P+13, P+16, P+19, ...; no act pulses after the release is accepted.
5. Early release: btn_in[1] held so that level stays high for only 7 cycles -> one act pulse, one press and one release; the FSM returns to IDLE with no repeat pulse.
6. Simultaneous and reset mid-op: izq and der pressed in the same cycle -> press pulses coincide. Asserting reset during REPEAT -> all outputs 0 immediately (asynchronous), and no pulse follows the release of reset until the button is debounced again.
